// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the elastic pipeline stage register.
//
// Contents:
//   - default control/data widths for pipe_stage_buf
//   - per-boundary widths (IF/ID, ID/EX, EX/MEM, MEM/WB)
//   - bit offsets used to pack the ID/EX control and data fields
//   - pack helpers for the ID/EX fields
//
// Field layouts are LSB-first.
//   ID/EX ctrl: [0] alu_src, [4:1] alu_control, [5] branch, [6] mem_write,
//               [7] mem_read, [8] reg_write_en, [9] mem_to_reg
//   ID/EX data: [4:0] rd, [9:5] rs2, [14:10] rs1, [78:15] imm,
//               [142:79] rd2, [206:143] rd1, [270:207] pc
package pipe_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned REG_IDX_W = 5;

    // ID/EX control field offsets
    localparam int unsigned ID_EX_CTRL_ALU_SRC      = 0;
    localparam int unsigned ID_EX_CTRL_ALU_CTRL_LSB = 1;
    localparam int unsigned ID_EX_CTRL_ALU_CTRL_W   = 4;
    localparam int unsigned ID_EX_CTRL_BRANCH       = 5;
    localparam int unsigned ID_EX_CTRL_MEM_WRITE    = 6;
    localparam int unsigned ID_EX_CTRL_MEM_READ     = 7;
    localparam int unsigned ID_EX_CTRL_REG_WRITE_EN = 8;
    localparam int unsigned ID_EX_CTRL_MEM_TO_REG   = 9;
    localparam int unsigned ID_EX_CTRL_W            = 10;

    // ID/EX data field offsets
    localparam int unsigned ID_EX_RD_LSB  = 0;
    localparam int unsigned ID_EX_RS2_LSB = ID_EX_RD_LSB + REG_IDX_W;
    localparam int unsigned ID_EX_RS1_LSB = ID_EX_RS2_LSB + REG_IDX_W;
    localparam int unsigned ID_EX_IMM_LSB = ID_EX_RS1_LSB + REG_IDX_W;
    localparam int unsigned ID_EX_RD2_LSB = ID_EX_IMM_LSB + XLEN;
    localparam int unsigned ID_EX_RD1_LSB = ID_EX_RD2_LSB + XLEN;
    localparam int unsigned ID_EX_PC_LSB  = ID_EX_RD1_LSB + XLEN;
    localparam int unsigned ID_EX_PC_W    = XLEN;
    localparam int unsigned ID_EX_DATA_W  = ID_EX_PC_LSB + XLEN;

    // Defaults for pipe_stage_buf are the ID/EX boundary
    localparam int unsigned PIPE_CTRL_W = ID_EX_CTRL_W;
    localparam int unsigned PIPE_DATA_W = ID_EX_DATA_W;

    // IF/ID: no decoded controls yet; one bit reserved so the field is never empty
    localparam int unsigned IF_ID_CTRL_W = 1;
    localparam int unsigned IF_ID_DATA_W = XLEN + 32;                       // pc + instr

    // EX/MEM: mem_to_reg, reg_write_en, mem_read, mem_write
    localparam int unsigned EX_MEM_CTRL_W = 4;
    localparam int unsigned EX_MEM_DATA_W = XLEN + XLEN + REG_IDX_W;        // alu, rd2, rd

    // MEM/WB: mem_to_reg, reg_write_en
    localparam int unsigned MEM_WB_CTRL_W = 2;
    localparam int unsigned MEM_WB_DATA_W = XLEN + XLEN + REG_IDX_W;        // mem, alu, rd

    function automatic logic [ID_EX_CTRL_W-1:0] pack_id_ex_ctrl(
        input logic       mem_to_reg,
        input logic       reg_write_en,
        input logic       mem_read,
        input logic       mem_write,
        input logic       branch,
        input logic [3:0] alu_control,
        input logic       alu_src
    );
        logic [ID_EX_CTRL_W-1:0] c;
        c = '0;
        c[ID_EX_CTRL_ALU_SRC]                                      = alu_src;
        c[ID_EX_CTRL_ALU_CTRL_LSB +: ID_EX_CTRL_ALU_CTRL_W]        = alu_control;
        c[ID_EX_CTRL_BRANCH]                                       = branch;
        c[ID_EX_CTRL_MEM_WRITE]                                    = mem_write;
        c[ID_EX_CTRL_MEM_READ]                                     = mem_read;
        c[ID_EX_CTRL_REG_WRITE_EN]                                 = reg_write_en;
        c[ID_EX_CTRL_MEM_TO_REG]                                   = mem_to_reg;
        return c;
    endfunction

    function automatic logic [ID_EX_DATA_W-1:0] pack_id_ex_data(
        input logic [XLEN-1:0]      pc,
        input logic [XLEN-1:0]      rd1,
        input logic [XLEN-1:0]      rd2,
        input logic [XLEN-1:0]      imm,
        input logic [REG_IDX_W-1:0] rs1,
        input logic [REG_IDX_W-1:0] rs2,
        input logic [REG_IDX_W-1:0] rd
    );
        logic [ID_EX_DATA_W-1:0] d;
        d = '0;
        d[ID_EX_RD_LSB  +: REG_IDX_W] = rd;
        d[ID_EX_RS2_LSB +: REG_IDX_W] = rs2;
        d[ID_EX_RS1_LSB +: REG_IDX_W] = rs1;
        d[ID_EX_IMM_LSB +: XLEN]      = imm;
        d[ID_EX_RD2_LSB +: XLEN]      = rd2;
        d[ID_EX_RD1_LSB +: XLEN]      = rd1;
        d[ID_EX_PC_LSB  +: XLEN]      = pc;
        return d;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// pipe_slot: one beat of storage (valid + ctrl + data).
//
// Ports:
//   clk_i       clock, rising edge
//   clr_all_i   synchronous clear of valid, ctrl and data (reset)
//   clr_ctrl_i  synchronous clear of valid and ctrl; data holds (flush/bubble)
//   load_i      capture ctrl_i/data_i and mark the slot valid
//   ctrl_i      control field to capture
//   data_i      data field to capture
//   valid_o     slot holds a beat
//   ctrl_o      held control field (zero whenever valid_o is low)
//   data_o      held data field
//
// Priority: clr_all_i > clr_ctrl_i > load_i.
module pipe_slot #(
    parameter int unsigned CtrlW = 10,
    parameter int unsigned DataW = 271
) (
    input  logic             clk_i,
    input  logic             clr_all_i,
    input  logic             clr_ctrl_i,
    input  logic             load_i,
    input  logic [CtrlW-1:0] ctrl_i,
    input  logic [DataW-1:0] data_i,
    output logic             valid_o,
    output logic [CtrlW-1:0] ctrl_o,
    output logic [DataW-1:0] data_o
);

    logic             valid_d, valid_q;
    logic [CtrlW-1:0] ctrl_d, ctrl_q;
    logic [DataW-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clr_ctrl_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_all_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline stage register with valid/ready handshake,
// synchronous flush and bubble insertion (control field zeroed when empty).
//
// Build option: define PIPE_STAGE_SKID_EN to add a skid slot, which gives a
// registered in_ready with full throughput and occupancy up to 2. Without it
// the stage holds a single beat and in_ready is combinational from out_ready.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset; discards all beats, zeroes outputs
//   flush      synchronous kill of held beats; out_data is kept (pc for redirect)
//   in_valid   upstream beat present
//   in_ready   stage accepts a beat this cycle (0 during reset and flush)
//   in_ctrl    upstream control field
//   in_data    upstream data field
//   out_valid  beat presented downstream
//   out_ready  downstream accepts (0 = stall)
//   out_ctrl   presented control field (0 when no beat is presented)
//   out_data   presented data field (holds when the stage empties)
//   occupancy  number of beats held
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = PIPE_CTRL_W,
    parameter int unsigned DATA_W = PIPE_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              accept;
    logic              drain;

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              main_load;
    logic              main_clr;
    logic [CTRL_W-1:0] main_ctrl_in;
    logic [DATA_W-1:0] main_data_in;

    assign accept = in_valid && in_ready;
    assign drain  = main_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_load;
    logic              skid_clr;

    // skid_valid is a flop, so in_ready has no path from out_ready or in_valid.
    assign in_ready = !skid_valid && !flush && !reset;

    always_comb begin
        main_load    = 1'b0;
        main_clr     = 1'b0;
        skid_load    = 1'b0;
        skid_clr     = 1'b0;
        main_ctrl_in = in_ctrl;
        main_data_in = in_data;
        if (flush) begin
            main_clr = 1'b0 | 1'b1;
            skid_clr = 1'b1;
        end else if (drain && skid_valid) begin
            // Older skid beat advances; skid is refilled or freed.
            main_load    = 1'b1;
            main_ctrl_in = skid_ctrl;
            main_data_in = skid_data;
            if (accept) begin
                skid_load = 1'b1;
            end else begin
                skid_clr = 1'b1;
            end
        end else if (accept && (!main_valid || drain)) begin
            main_load = 1'b1;
        end else begin
            if (accept) begin
                skid_load = 1'b1;
            end
            if (drain) begin
                main_clr = 1'b1;
            end
        end
    end

    pipe_slot #(
        .CtrlW (CTRL_W),
        .DataW (DATA_W)
    ) u_skid (
        .clk_i      (clk),
        .clr_all_i  (reset),
        .clr_ctrl_i (skid_clr),
        .load_i     (skid_load),
        .ctrl_i     (in_ctrl),
        .data_i     (in_data),
        .valid_o    (skid_valid),
        .ctrl_o     (skid_ctrl),
        .data_o     (skid_data)
    );

    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

`else

    assign in_ready = (!main_valid || out_ready) && !flush && !reset;

    always_comb begin
        main_ctrl_in = in_ctrl;
        main_data_in = in_data;
        main_load    = accept && !flush;
        // Flush kills the beat; a drain with no replacement leaves a bubble.
        main_clr     = flush || (drain && !accept);
    end

    assign occupancy = {1'b0, main_valid};

`endif

    pipe_slot #(
        .CtrlW (CTRL_W),
        .DataW (DATA_W)
    ) u_main (
        .clk_i      (clk),
        .clr_all_i  (reset),
        .clr_ctrl_i (main_clr),
        .load_i     (main_load),
        .ctrl_i     (main_ctrl_in),
        .data_i     (main_data_in),
        .valid_o    (main_valid),
        .ctrl_o     (main_ctrl),
        .data_o     (main_data)
    );

    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int CW = 10;
    localparam int DW = 271;
`ifdef PIPE_STAGE_SKID_EN
    localparam int Cap = 2;
`else
    localparam int Cap = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    // Reference model: an ordered list of held beats plus last presented data.
    beat_t         mq[$];
    logic [DW-1:0] m_data = '0;

    pipe_stage_buf #(
        .CTRL_W (CW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic m_in_ready();
        if (reset || flush) return 1'b0;
        if (Cap == 2) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    function automatic logic m_out_valid();
        return mq.size() != 0;
    endfunction

    function automatic logic [CW-1:0] m_out_ctrl();
        if (mq.size() == 0) return '0;
        return mq[0].c;
    endfunction

    function automatic logic [1:0] m_occ();
        return 2'(mq.size());
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [287:0] t;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom();
        return t[DW-1:0];
    endfunction

    // Apply one clock edge with the current inputs and advance the model.
    task automatic tick();
        logic  acc;
        logic  drn;
        beat_t b;
        acc = in_valid && m_in_ready();
        drn = m_out_valid() && out_ready;
        b.c = in_ctrl;
        b.d = in_data;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_data = '0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(b);
        end
        if (mq.size() != 0) m_data = mq[0].d;
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 10'h3FF;
        in_data   = rand_data();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_in_ready got=%b required=0", in_ready);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%b required=0", out_valid);
        end
        total++;
        if (out_ctrl !== '0) begin
            bad++; $display("FAIL reset_out_ctrl got=%h required=0", out_ctrl);
        end
        total++;
        if (out_data !== '0) begin
            bad++; $display("FAIL reset_out_data got=%h required=0", out_data);
        end
        total++;
        if (occupancy !== 2'd0) begin
            bad++; $display("FAIL reset_occupancy got=%0d required=0", occupancy);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_in_ready got=%b required=1", in_ready);
        end
        tick();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_ctrl  = CW'($urandom());
            in_data  = DW'(i);
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL stream_in_ready beat=%0d got=%b required=1", i, in_ready);
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== DW'(i) || out_ctrl !== m_out_ctrl()) begin
                bad++;
                $display("FAIL stream_out beat=%0d got v=%b d=%0h c=%h required v=1 d=%0h c=%h",
                         i, out_valid, out_data, out_ctrl, i, m_out_ctrl());
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== DW'(8)) begin
            bad++;
            $display("FAIL stream_tail got v=%b c=%h d=%0h required v=0 c=0 d=8",
                     out_valid, out_ctrl, out_data);
        end
    endtask

    task automatic test_stall();
        int   next     = 1;
        int   exp_next = 1;
        int   max_occ  = 0;
        logic saw_low  = 1'b0;
        logic acc;
        for (int cyc = 0; cyc < 12; cyc++) begin
            in_valid  = (next <= 4);
            in_data   = DW'(next);
            in_ctrl   = CW'($urandom());
            out_ready = !(cyc >= 2 && cyc <= 4);
            #1;
            total++;
            if (in_ready !== m_in_ready()) begin
                bad++;
                $display("FAIL stall_in_ready cyc=%0d got=%b required=%b", cyc, in_ready, m_in_ready());
            end
            if (in_ready === 1'b0) saw_low = 1'b1;
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            if (m_out_valid() && out_ready) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== DW'(exp_next)) begin
                    bad++;
                    $display("FAIL stall_order cyc=%0d got v=%b d=%0h required v=1 d=%0h",
                             cyc, out_valid, out_data, exp_next);
                end
                exp_next++;
            end
            acc = in_valid && m_in_ready();
            tick();
            if (acc) next++;
        end
        total++;
        if (exp_next != 5) begin
            bad++; $display("FAIL stall_count got=%0d required=4", exp_next - 1);
        end
        total++;
        if (max_occ != Cap) begin
            bad++; $display("FAIL stall_max_occupancy got=%0d required=%0d", max_occ, Cap);
        end
        total++;
        if (saw_low !== 1'b1) begin
            bad++; $display("FAIL stall_in_ready_fell got=%b required=1", saw_low);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 10'h155;
        for (int i = 0; i < 2; i++) begin
            in_data = pack_id_ex_data(64'h40, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                                      {$urandom(), $urandom()}, 5'($urandom()),
                                      5'($urandom()), 5'($urandom()));
            tick();
        end
        total++;
        if (occupancy !== 2'(Cap)) begin
            bad++; $display("FAIL flush_pre_occupancy got=%0d required=%0d", occupancy, Cap);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = rand_data();
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL flush_in_ready got=%b required=0", in_ready);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0) begin
            bad++;
            $display("FAIL flush_empty got v=%b c=%h occ=%0d required v=0 c=0 occ=0",
                     out_valid, out_ctrl, occupancy);
        end
        total++;
        if (out_data[ID_EX_PC_LSB +: ID_EX_PC_W] !== 64'h40 || out_data !== m_data) begin
            bad++;
            $display("FAIL flush_pc_hold got=%h required=40",
                     out_data[ID_EX_PC_LSB +: ID_EX_PC_W]);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            bad++;
            $display("FAIL flush_no_accept got v=%b occ=%0d required v=0 occ=0", out_valid, occupancy);
        end
    endtask

    task automatic test_bubble();
        logic [DW-1:0] d;
        d         = rand_data();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 10'h2AA;
        in_data   = d;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_ctrl !== 10'h2AA) begin
            bad++;
            $display("FAIL bubble_load got v=%b c=%h required v=1 c=2aa", out_valid, out_ctrl);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== d) begin
            bad++;
            $display("FAIL bubble_zero got v=%b c=%h d=%h required v=0 c=0 d=%h",
                     out_valid, out_ctrl, out_data, d);
        end
    endtask

    task automatic test_ready_path();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = CW'($urandom());
        in_data   = rand_data();
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (in_ready !== m_in_ready()) begin
            bad++;
            $display("FAIL ready_stalled got=%b required=%b", in_ready, m_in_ready());
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL ready_released got=%b required=1", in_ready);
        end
        tick();
    endtask

    task automatic test_random();
        int acc_cnt = 0;
        int cyc     = 0;
        while (acc_cnt < 1000 && cyc < 8000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 2);
            reset     = ($urandom_range(0, 199) == 0);
            in_ctrl   = CW'($urandom());
            in_data   = rand_data();
            #1;
            total++;
            if (in_ready !== m_in_ready()) begin
                bad++;
                $display("FAIL rand_in_ready cyc=%0d got=%b required=%b", cyc, in_ready, m_in_ready());
            end
            total++;
            if (out_valid !== m_out_valid() || out_ctrl !== m_out_ctrl() || out_data !== m_data) begin
                bad++;
                $display("FAIL rand_out cyc=%0d got v=%b c=%h required v=%b c=%h (data equal=%b)",
                         cyc, out_valid, out_ctrl, m_out_valid(), m_out_ctrl(), out_data === m_data);
            end
            total++;
            if (occupancy !== m_occ() || int'(occupancy) > Cap) begin
                bad++;
                $display("FAIL rand_occupancy cyc=%0d got=%0d required=%0d", cyc, occupancy, m_occ());
            end
            if (in_valid && m_in_ready()) acc_cnt++;
            tick();
            cyc++;
        end
        flush    = 1'b0;
        reset    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (acc_cnt < 1000) begin
            bad++; $display("FAIL rand_budget got=%0d required=1000", acc_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_bubble();
        test_ready_path();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline stage register carrying one control field and one data field per beat with a valid/ready handshake, synchronous flush and bubble insertion. It replaces the fixed-field, always-advancing ID/EX-style latch, and is instantiated at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). Stalls are expressed as back-pressure rather than a separate enable. An optional skid entry gives full throughput with a registered `in_ready`.

## Interface
Parameters:
- `CTRL_W`, default 10: control bits per beat (WB/MEM/EX controls). Zeroed on flush and whenever no valid beat is held.
- `DATA_W`, default 271: data bits per beat (pc, two operands, immediate, rs1/rs2/rd). Never zeroed except by reset.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `flush`, in, 1: synchronous kill of all held beats.
- `in_valid`, in, 1: upstream beat present.
- `in_ready`, out, 1: stage can accept a beat this cycle.
- `in_ctrl`, in, CTRL_W: upstream control field.
- `in_data`, in, DATA_W: upstream data field.
- `out_valid`, out, 1: beat presented downstream.
- `out_ready`, in, 1: downstream accepts (0 = stall).
- `out_ctrl`, out, CTRL_W: presented control field.
- `out_data`, out, DATA_W: presented data field.
- `occupancy`, out, 2: beats held (0..2; max 1 without skid).

## Operation
- Accept = `in_valid && in_ready`; drain = `out_valid && out_ready`.
- Two slots: main (drives outputs) and skid.
- On accept:
  - If main is empty or draining and skid is empty, the beat loads into main.
  - Otherwise the beat loads into skid.
- On drain with skid valid: skid moves to main, and the skid slot is freed or reloaded by a simultaneous accept. Order is strictly FIFO.
- Bubble: when main becomes empty, `out_ctrl` is loaded with 0. `out_data` holds its last value. Downstream logic that ignores valid therefore sees all-zero controls (no reg write, no mem access, no branch).
- Flush, priority below reset and above everything else:
  - Next cycle both slots are invalid, `occupancy`=0 and `out_ctrl`=0.
  - `out_data` holds its prior value, so the pc is retained for redirect logic.
  - `in_ready` is forced 0 during `flush`, so no beat is accepted in a flush cycle.
- Reset:
  - Outputs the cycle after reset is sampled high: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, `in_ready`=0 while reset is high.
  - `in_ready`=1 from the first cycle after reset is low.
  - Reset mid-transfer discards all beats.
- `in_ready` does not depend combinationally on `in_valid`. `out_valid` does not depend combinationally on `out_ready`.

## Timing
- Latency: a beat accepted at edge N appears on the outputs after edge N (one cycle).
- Throughput: one beat per cycle with `out_ready` held high.
- Skid mode: `in_ready` = registered `!skid_valid`, and `!flush`.
  - After one stall cycle with a continuous stream, skid fills and `in_ready` drops the following cycle.
  - It rises the cycle after the first drain.
- Simultaneous accept and drain with one beat held: `occupancy` stays 1 and the outputs update to the new beat.
- Simultaneous `flush` and `out_ready`: the drain still completes downstream on that edge, but the stage is empty afterwards.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - Skid slot present; behaviour is as above.
  - `in_ready` is registered.
  - `occupancy` reaches 2.
- `PIPE_STAGE_SKID_EN` undefined:
  - Main slot only.
  - `in_ready = (!out_valid || out_ready) && !flush && !reset`, which is combinational from `out_ready`.
  - `occupancy` never exceeds 1.
  - All flush, bubble and reset rules are unchanged.

## Structure
- Package `pipe_pkg` holds:
  - Default `CTRL_W`/`DATA_W` constants.
  - Per-boundary width constants (`IF_ID_*`, `ID_EX_*`, `EX_MEM_*`, `MEM_WB_*`).
  - Field offset constants for packing the ID/EX control field (mem_to_reg, reg_write_en, mem_read, mem_write, branch, alu_control[3:0], alu_src) and the data field (pc, rd1, rd2, imm, rs1, rs2, rd).
- One sub-module, `pipe_slot`: a single valid + ctrl + data register with load, clear-ctrl and clear-all controls. It is instantiated once for main and once for skid under the macro.

## Test plan
- Reset: assert `reset` for 2 cycles with `in_valid`=1, `in_ctrl`=10'h3FF → `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0; `in_ready`=1 one cycle after release.
- Streaming: 8 beats with `in_data`=1..8, `out_ready`=1 → outputs are 1..8 on consecutive cycles, one cycle after each accept, and none is lost.
- Stall (skid): stream 1..4 with `out_ready`=0 from beat 2 for 3 cycles → `occupancy` reaches 2 and `in_ready` falls; after release, outputs are 2,3,4 in order with no duplicates.
- Flush: two beats held (ctrl 10'h155, data pc=0x40), pulse `flush` → next cycle `out_valid`=0, `out_ctrl`=0, `out_data` pc field still 0x40, `occupancy`=0; an `in_valid` offered during the flush cycle is not accepted.
- Bubble: a single beat (ctrl 10'h2AA) drained with no follow-up → `out_ctrl`=0 on the next cycle while `out_data` holds.
- No-skid build: `out_ready`=0 → `in_ready`=0 in the same cycle; `out_ready`=1 → `in_ready`=1 in the same cycle; `occupancy` ≤ 1 throughout a random 1000-beat run checked against a reference FIFO model.
